// File: rtl/mure_pkg.sv
// Field widths shared by the trace encoder blocks.
package mure_pkg;
  localparam int XLEN        = 64;
  localparam int IRETIRE_LEN = 14;
  localparam int ITYPE_LEN   = 3;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;
endpackage

// File: rtl/te_block_receiver_if.sv
// Block strobe from the retirement FSM, valid/ready head presentation and status.
// master drives the strobe and ready; slave is the receiver.
interface te_block_receiver_if #(
  parameter int DEPTH      = 4,
  parameter int DROP_CNT_W = 16
);
  logic                            valid_i;
  logic [mure_pkg::XLEN-1:0]       iaddr_i;
  logic [mure_pkg::IRETIRE_LEN-1:0] iretire_i;
  logic                            ilastsize_i;
  logic [mure_pkg::ITYPE_LEN-1:0]  itype_i;
  logic [mure_pkg::CAUSE_LEN-1:0]  cause_i;
  logic [mure_pkg::XLEN-1:0]       tval_i;
  logic [mure_pkg::PRIV_LEN-1:0]   priv_i;

  logic                            valid_o;
  logic                            ready_i;
  logic [mure_pkg::XLEN-1:0]       iaddr_o;
  logic [mure_pkg::IRETIRE_LEN-1:0] iretire_o;
  logic                            ilastsize_o;
  logic [mure_pkg::ITYPE_LEN-1:0]  itype_o;
  logic [mure_pkg::CAUSE_LEN-1:0]  cause_o;
  logic [mure_pkg::XLEN-1:0]       tval_o;
  logic [mure_pkg::PRIV_LEN-1:0]   priv_o;
  logic [mure_pkg::XLEN-1:0]       last_iaddr_o;
  logic [$clog2(DEPTH):0]          count_o;
  logic                            overflow_o;
  logic                            malformed_o;
  logic [DROP_CNT_W-1:0]           drop_cnt_o;

  modport master (
    output valid_i, iaddr_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, ready_i,
    input  valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o,
           last_iaddr_o, count_o, overflow_o, malformed_o, drop_cnt_o
  );

  modport slave (
    input  valid_i, iaddr_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, ready_i,
    output valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o,
           last_iaddr_o, count_o, overflow_o, malformed_o, drop_cnt_o
  );
endinterface

// File: rtl/te_block_receiver.sv
// Captures un-stallable instruction-block strobes into a FIFO and presents them
// downstream over valid/ready, counting and flagging dropped blocks.
module te_block_receiver
  import mure_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  te_block_receiver_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        last_iaddr;
  } entry_t;

  entry_t                mem [DEPTH];
  entry_t                wr_entry;
  entry_t                head_entry;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  malformed;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  bad_len;
  logic                  ovf_hit;
  logic                  drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    pop     = !empty && bus.ready_i;
    bad_len = bus.valid_i && (bus.iretire_i == '0);
    ovf_hit = bus.valid_i && full && !pop;
    push    = bus.valid_i && !bad_len && (!full || pop);
    drop    = bad_len || ovf_hit;
  end

  always_comb begin
    wr_entry            = '0;
    wr_entry.iaddr      = bus.iaddr_i;
    wr_entry.iretire    = bus.iretire_i;
    wr_entry.ilastsize  = bus.ilastsize_i;
    wr_entry.itype      = bus.itype_i;
    wr_entry.cause      = bus.cause_i;
    wr_entry.tval       = bus.tval_i;
    wr_entry.priv       = bus.priv_i;
    wr_entry.last_iaddr = bus.iaddr_i + (XLEN'(bus.iretire_i) << 1)
                          - (bus.ilastsize_i ? XLEN'(4) : XLEN'(2));
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[tail] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      malformed <= 1'b0;
      drop_cnt  <= '0;
    end else if (flush_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      malformed <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
      if (bad_len) begin
        malformed <= 1'b1;
      end
      // A block that is both malformed and arrives on a full FIFO counts once.
      if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    head_entry = empty ? '0 : mem[head];
  end

  assign bus.valid_o      = !empty;
  assign bus.iaddr_o      = head_entry.iaddr;
  assign bus.iretire_o    = head_entry.iretire;
  assign bus.ilastsize_o  = head_entry.ilastsize;
  assign bus.itype_o      = head_entry.itype;
  assign bus.cause_o      = head_entry.cause;
  assign bus.tval_o       = head_entry.tval;
  assign bus.priv_o       = head_entry.priv;
  assign bus.last_iaddr_o = head_entry.last_iaddr;
  assign bus.count_o      = count;
  assign bus.overflow_o   = overflow;
  assign bus.malformed_o  = malformed;
  assign bus.drop_cnt_o   = drop_cnt;
endmodule

// File: tb/tb_te_block_receiver.sv
// Scoreboard bench for te_block_receiver: a queue-based reference model predicts
// delivered blocks, occupancy, flags and drop count for directed and random traffic.
module tb_te_block_receiver;
  import mure_pkg::*;

  localparam int DEPTH    = 4;
  localparam int DW       = 4;
  localparam int DROP_MAX = (1 << DW) - 1;

  typedef struct {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        last_iaddr;
  } exp_t;

  logic clk;
  logic rst_ni;
  logic flush_i;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];
  int   cur_occ = 0, nxt_occ = 0;
  int   cur_drops = 0, nxt_drops = 0;
  logic cur_ovf = 1'b0, nxt_ovf = 1'b0;
  logic cur_mal = 1'b0, nxt_mal = 1'b0;

  te_block_receiver_if #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) bus ();

  te_block_receiver #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: retire the model's previous prediction, drive new inputs,
  // then predict what the coming edge will do.
  task automatic applyStimulus(input logic v, input logic [XLEN-1:0] a, input int r, input logic ls,
                               input int ty, input int cs, input logic [XLEN-1:0] tv, input int pv,
                               input logic rdy, input logic fl);
    exp_t e;
    logic pop, full, bad, ovf, push;
    @(posedge clk);
    #1;
    cur_occ   = nxt_occ;
    cur_drops = nxt_drops;
    cur_ovf   = nxt_ovf;
    cur_mal   = nxt_mal;
    bus.valid_i     = v;
    bus.iaddr_i     = a;
    bus.iretire_i   = r[IRETIRE_LEN-1:0];
    bus.ilastsize_i = ls;
    bus.itype_i     = ty[ITYPE_LEN-1:0];
    bus.cause_i     = cs[CAUSE_LEN-1:0];
    bus.tval_i      = tv;
    bus.priv_i      = pv[PRIV_LEN-1:0];
    bus.ready_i     = rdy;
    flush_i         = fl;
    if (fl) begin
      nxt_occ = 0; nxt_drops = 0; nxt_ovf = 1'b0; nxt_mal = 1'b0;
      exp_q.delete();
    end else begin
      pop  = (cur_occ > 0) && rdy;
      full = (cur_occ == DEPTH);
      bad  = v && (bus.iretire_i == 0);
      ovf  = v && full && !pop;
      push = v && !bad && !ovf;
      if (bad) nxt_mal = 1'b1;
      if (ovf) nxt_ovf = 1'b1;
      if ((bad || ovf) && cur_drops < DROP_MAX) nxt_drops = cur_drops + 1;
      nxt_occ = cur_occ + (push ? 1 : 0) - (pop ? 1 : 0);
      if (push) begin
        e.iaddr      = a;
        e.iretire    = bus.iretire_i;
        e.ilastsize  = ls;
        e.itype      = bus.itype_i;
        e.cause      = bus.cause_i;
        e.tval       = tv;
        e.priv       = bus.priv_i;
        e.last_iaddr = a + 64'(bus.iretire_i) * 2 - (ls ? 64'd4 : 64'd2);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, '0, 0, 1'b0, 0, 0, '0, 0, rdy, 1'b0);
  endtask

  task automatic strobe(input logic [XLEN-1:0] a, input int r, input logic ls, input logic rdy);
    applyStimulus(1'b1, a, r, ls, r % 4, r % 17, a ^ 64'h5a5a, r % 4, rdy, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus.valid_o), '0);
    checkOutput({tag, "_count"}, 64'(bus.count_o), '0);
    checkOutput({tag, "_overflow"}, 64'(bus.overflow_o), '0);
    checkOutput({tag, "_malformed"}, 64'(bus.malformed_o), '0);
    checkOutput({tag, "_drop_cnt"}, 64'(bus.drop_cnt_o), '0);
    checkOutput({tag, "_fields"}, 64'(|{bus.iaddr_o, bus.iretire_o, bus.ilastsize_o, bus.itype_o,
                                        bus.cause_o, bus.tval_o, bus.priv_o, bus.last_iaddr_o}), '0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni) begin
      checkOutput("valid", 64'(bus.valid_o), 64'(cur_occ > 0));
      checkOutput("count", 64'(bus.count_o), 64'(cur_occ));
      checkOutput("overflow", 64'(bus.overflow_o), 64'(cur_ovf));
      checkOutput("malformed", 64'(bus.malformed_o), 64'(cur_mal));
      checkOutput("drop_cnt", 64'(bus.drop_cnt_o), 64'(cur_drops));
      if (!bus.valid_o) begin
        checkOutput("empty_fields", 64'(|{bus.iaddr_o, bus.iretire_o, bus.ilastsize_o, bus.itype_o,
                                         bus.cause_o, bus.tval_o, bus.priv_o, bus.last_iaddr_o}), '0);
      end else if (bus.ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pop", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("iaddr", bus.iaddr_o, e.iaddr);
          checkOutput("iretire", 64'(bus.iretire_o), 64'(e.iretire));
          checkOutput("ilastsize", 64'(bus.ilastsize_o), 64'(e.ilastsize));
          checkOutput("itype", 64'(bus.itype_o), 64'(e.itype));
          checkOutput("cause", 64'(bus.cause_o), 64'(e.cause));
          checkOutput("tval", bus.tval_o, e.tval);
          checkOutput("priv", 64'(bus.priv_o), 64'(e.priv));
          checkOutput("last_iaddr", bus.last_iaddr_o, e.last_iaddr);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    bus.valid_i = 1'b0; bus.iaddr_i = '0; bus.iretire_i = '0; bus.ilastsize_i = 1'b0;
    bus.itype_i = '0; bus.cause_i = '0; bus.tval_i = '0; bus.priv_i = '0; bus.ready_i = 1'b0;
    #3;
    checkAllZero("reset");
    @(posedge clk);
    #2 rst_ni = 1'b1;

    applyStimulus(1'b1, 64'h8000_0000, 5, 1'b0, 2, 0, '0, 3, 1'b1, 1'b0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("single_iretire", 64'(bus.iretire_o), 64'd5);
    checkOutput("single_last_iaddr", bus.last_iaddr_o, 64'h8000_0008);
    idleCycle(1'b1);

    applyStimulus(1'b1, 64'h1000, 6, 1'b1, 1, 3, 64'hdead, 1, 1'b1, 1'b0);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("w32_last_iaddr", bus.last_iaddr_o, 64'h1008);
    checkOutput("w32_cause", 64'(bus.cause_o), 64'd3);
    checkOutput("w32_tval", bus.tval_o, 64'hdead);
    idleCycle(1'b1);

    for (int i = 0; i < 6; i++) strobe(64'h2000 + 64'(i * 16), i + 1, i[0], 1'b0);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("ovf_count", 64'(bus.count_o), 64'd4);
    checkOutput("ovf_flag", 64'(bus.overflow_o), 64'd1);
    checkOutput("ovf_drops", 64'(bus.drop_cnt_o), 64'd2);
    for (int i = 0; i < 5; i++) idleCycle(1'b1);

    for (int i = 0; i < 4; i++) strobe(64'h3000 + 64'(i * 8), 3, 1'b0, 1'b0);
    strobe(64'h3F00, 7, 1'b1, 1'b1);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("pushpop_count", 64'(bus.count_o), 64'd4);
    checkOutput("pushpop_drops", 64'(bus.drop_cnt_o), 64'd2);
    for (int i = 0; i < 5; i++) idleCycle(1'b1);

    strobe(64'h4000, 0, 1'b0, 1'b0);
    idleCycle(1'b0);
    @(negedge clk);
    checkOutput("malformed_flag", 64'(bus.malformed_o), 64'd1);
    checkOutput("malformed_count", 64'(bus.count_o), 64'd0);

    for (int i = 0; i < 3; i++) strobe(64'h5000 + 64'(i * 4), 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h5100, 4, 1'b0, 0, 0, '0, 0, 1'b1, 1'b1);
    idleCycle(1'b0);
    @(negedge clk);
    checkAllZero("flush");

    strobe(64'hFFFF_FFFF_FFFF_FFFE, 2, 1'b1, 1'b1);
    idleCycle(1'b1);
    @(negedge clk);
    checkOutput("wrap_last_iaddr", bus.last_iaddr_o, 64'hFFFF_FFFF_FFFF_FFFE);
    idleCycle(1'b1);

    strobe(64'h6000, 9, 1'b0, 1'b0);
    strobe(64'h6100, 0, 1'b0, 1'b0);
    strobe(64'h6200, 4, 1'b1, 1'b0);
    idleCycle(1'b0);
    #2 rst_ni = 1'b0;
    #1;
    checkAllZero("async_reset");
    exp_q.delete();
    cur_occ = 0; nxt_occ = 0; cur_drops = 0; nxt_drops = 0;
    cur_ovf = 1'b0; nxt_ovf = 1'b0; cur_mal = 1'b0; nxt_mal = 1'b0;
    @(posedge clk);
    #2 rst_ni = 1'b1;
    strobe(64'h7000, 3, 1'b0, 1'b1);
    idleCycle(1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                    {$urandom, $urandom}, int'($urandom_range(0, 3)),
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2);
    end
    for (int i = 0; i < 8; i++) idleCycle(1'b1);
    @(negedge clk);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
